axi_read_burst_splitter: RTL and testbench

//  AXI4 read-channel burst splitter between an upstream master and a downstream in-order slave.

---
 rtl/axi_rd_split_pkg.sv | 41 ++++
 rtl/axi_read_if.sv | 23 ++
 rtl/axi_rd_split_checker.sv | 10 +
 rtl/axi_rd_split_fifo.sv | 83 ++++++++
 rtl/axi_read_burst_splitter.sv | 155 +++++++++++++++
 tb/tb_axi_read_burst_splitter.sv | 283 ++++++++++++++++++++++++++++
 6 files changed

// File: rtl/axi_rd_split_pkg.sv
// Shared types and constants for the AXI4 read burst splitter.
package axi_rd_split_pkg;

  localparam int ID_W = 4;

  typedef logic [31:0]     addr_t;
  typedef logic [31:0]     data_t;
  typedef logic [ID_W-1:0] id_t;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {
    IDLE  = 1'b0,
    SPLIT = 1'b1
  } split_state_e;

  // is_final marks the last sub-burst of an upstream burst
  typedef struct packed {
    logic is_final;
  } split_entry_t;

  // Beats in the next sub-burst; WRAP bursts always go out whole
  function automatic logic [8:0] sub_beats(input logic [8:0] rem,
                                           input logic [1:0] burst,
                                           input logic [8:0] max_beats);
    if (burst == BURST_WRAP) begin
      return rem;
    end else if (rem > max_beats) begin
      return max_beats;
    end else begin
      return rem;
    end
  endfunction

endpackage

// File: rtl/axi_read_if.sv
// AXI4 read-channel bundle (AR + R) with source/destination views.
interface axi_read_if;
  import axi_rd_split_pkg::*;

  id_t        arid;
  addr_t      araddr;
  logic [7:0] arlen;
  logic [2:0] arsize;
  logic [1:0] arburst;
  logic       arvalid;
  logic       arready;
  id_t        rid;
  data_t      rdata;
  logic [1:0] rresp;
  logic       rlast;
  logic       rvalid;
  logic       rready;

  modport src (output arid, araddr, arlen, arsize, arburst, arvalid, rready,
               input  arready, rid, rdata, rresp, rlast, rvalid);
  modport dst (input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
               output arready, rid, rdata, rresp, rlast, rvalid);
endinterface

// File: rtl/axi_rd_split_checker.sv
// Protocol checks around the splitter's downstream read path.
module axi_rd_split_checker (
  input logic clk,
  input logic rst,
  input logic dn_rvalid,
  input logic fifo_empty
);
  // Read data may only arrive for a sub-burst that has been issued
  a_no_orphan_r: assert property (@(posedge clk) disable iff (rst) dn_rvalid |-> !fifo_empty);
endmodule

// File: rtl/axi_rd_split_fifo.sv
// Tracking FIFO: one entry per downstream sub-burst in flight, in issue order.
module axi_rd_split_fifo
  import axi_rd_split_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  split_entry_t push_data,
  input  logic         pop,
  output split_entry_t head,
  output logic         full,
  output logic         empty
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  split_entry_t     mem_q [DEPTH];
  split_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push_s, do_pop_s;

  // Pointers wrap explicitly so non-power-of-two depths work
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_LAST) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  assign full      = (cnt_q == CNT_FULL);
  assign empty     = (cnt_q == {CNT_W{1'b0}});
  assign head      = mem_q[rd_ptr_q];
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;

  // Next storage, pointer and occupancy values
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push_s) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // FIFO state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= split_entry_t'(1'b0);
      end
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/axi_read_burst_splitter.sv
// AXI4 read burst splitter: breaks long INCR/FIXED bursts into sub-bursts of
// at most MAX_BEATS beats and merges the returned data into one upstream burst.
// Optional feature: define AXI_RD_SPLIT_ERR_STICKY_EN to make the first error
// response of an upstream burst sticky for the rest of that burst.
module axi_read_burst_splitter
  import axi_rd_split_pkg::*;
#(
  parameter int MAX_BEATS   = 16,
  parameter int OUTSTANDING = 4
) (
  input logic     clk,
  input logic     rst,
  axi_read_if.dst up,
  axi_read_if.src dn
);
  split_state_e state_q, state_d;
  id_t          id_q, id_d;
  addr_t        addr_q, addr_d;
  logic [2:0]   size_q, size_d;
  logic [1:0]   burst_q, burst_d;
  logic [8:0]   rem_q, rem_d;
  logic [8:0]   sub_s;
  logic         ar_hs_s, push_s, pop_s, full_s, empty_s;
  split_entry_t push_entry_s, head_s;

  assign sub_s   = sub_beats(rem_q, burst_q, 9'(MAX_BEATS));
  assign ar_hs_s = dn.arvalid && dn.arready;

  // AR FSM: capture the upstream request, then walk it out in sub-bursts
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    addr_d  = addr_q;
    size_d  = size_q;
    burst_d = burst_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (up.arvalid) begin
          id_d    = up.arid;
          addr_d  = up.araddr;
          size_d  = up.arsize;
          burst_d = up.arburst;
          rem_d   = {1'b0, up.arlen} + 9'd1;
          state_d = SPLIT;
        end else begin
          state_d = IDLE;
        end
      end
      SPLIT: begin
        if (ar_hs_s) begin
          rem_d = rem_q - sub_s;
          case (burst_q)
            BURST_INCR:  addr_d = addr_q + (addr_t'(sub_s) << size_q);
            BURST_FIXED: addr_d = addr_q;
            default:     addr_d = addr_q;
          endcase
          if (rem_q == sub_s) begin
            state_d = IDLE;
          end else begin
            state_d = SPLIT;
          end
        end else begin
          state_d = SPLIT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // AR FSM and captured request registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      id_q    <= {ID_W{1'b0}};
      addr_q  <= 32'h0000_0000;
      size_q  <= 3'd0;
      burst_q <= BURST_FIXED;
      rem_q   <= 9'd0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      rem_q   <= rem_d;
    end
  end

  assign up.arready = (state_q == IDLE);
  assign dn.arvalid = (state_q == SPLIT) && !full_s;
  assign dn.arid    = id_q;
  assign dn.araddr  = addr_q;
  assign dn.arlen   = 8'(sub_s - 9'd1);
  assign dn.arsize  = size_q;
  assign dn.arburst = burst_q;

  assign push_s                = ar_hs_s;
  assign push_entry_s.is_final = (rem_q == sub_s);
  assign pop_s                 = dn.rvalid && dn.rready && dn.rlast;

  axi_rd_split_fifo #(.DEPTH(OUTSTANDING)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_data (push_entry_s),
    .pop       (pop_s),
    .head      (head_s),
    .full      (full_s),
    .empty     (empty_s)
  );

  axi_rd_split_checker u_chk (
    .clk        (clk),
    .rst        (rst),
    .dn_rvalid  (dn.rvalid),
    .fifo_empty (empty_s)
  );

  assign up.rvalid = dn.rvalid;
  assign dn.rready = up.rready;
  assign up.rid    = dn.rid;
  assign up.rdata  = dn.rdata;
  assign up.rlast  = dn.rlast && head_s.is_final;

`ifdef AXI_RD_SPLIT_ERR_STICKY_EN
  logic [1:0] err_q, err_d;

  // Hold the first error of the upstream burst until its last beat
  always_comb begin
    err_d = err_q;
    if (up.rvalid && up.rready && up.rlast) begin
      err_d = RESP_OKAY;
    end else if (dn.rvalid && dn.rready && (err_q == RESP_OKAY)) begin
      err_d = dn.rresp;
    end else begin
      err_d = err_q;
    end
  end

  // Sticky error register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= RESP_OKAY;
    end else begin
      err_q <= err_d;
    end
  end

  assign up.rresp = (err_q != RESP_OKAY) ? err_q : dn.rresp;
`else
  assign up.rresp = dn.rresp;
`endif

endmodule

// File: tb/tb_axi_read_burst_splitter.sv
// Self-checking bench for axi_read_burst_splitter: directed cases plus
// randomized bursts with backpressure against a burst-level reference model.
module tb_axi_read_burst_splitter;

  localparam int MAXB     = 16;
  localparam int OUTS     = 2;
  localparam int ERR_BEAT = 5;
  localparam logic [1:0] B_FIXED = 2'b00;
  localparam logic [1:0] B_INCR  = 2'b01;
  localparam logic [1:0] B_WRAP  = 2'b10;
  localparam logic [1:0] R_OKAY  = 2'b00;
  localparam logic [1:0] R_SLV   = 2'b10;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } ar_t;
  typedef struct { logic [3:0] id; int beats; } up_t;
  typedef struct { logic [3:0] id; logic [7:0] len; } sl_t;
  typedef struct { logic [31:0] addr; logic [7:0] len; } log_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi_read_if up_if ();
  axi_read_if dn_if ();

  axi_read_burst_splitter #(.MAX_BEATS(MAXB), .OUTSTANDING(OUTS)) dut (
    .clk (clk),
    .rst (rst),
    .up  (up_if),
    .dn  (dn_if)
  );

  int n_chk = 0;
  int n_err = 0;
  ar_t  send_q[$];
  ar_t  exp_ar_q[$];
  up_t  up_q[$];
  sl_t  sl_q[$];
  log_t dn_log[$];
  int   ar_ticks[$];
  int   pop_ticks[$];
  int   up_beat = 0, sl_beat = 0, done_bursts = 0, err_burst = -1;
  int   cycle = 0, dn_ar_cnt = 0;
  int   p_arv = 100, p_rready = 100, p_arready = 100, p_rvalid = 100;
  bit   slave_r_en = 1'b1, ar_clear = 1'b0, r_clear = 1'b0;
  logic [31:0] sl_data;
  ar_t  cur;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: one upstream burst becomes a list of downstream bursts
  task automatic model_accept(input ar_t a);
    int beats, n;
    logic [31:0] addr;
    ar_t s;
    up_q.push_back('{a.id, int'(a.len) + 1});
    beats = int'(a.len) + 1;
    addr  = a.addr;
    if (a.burst == B_WRAP) begin
      exp_ar_q.push_back(a);
    end else begin
      while (beats > 0) begin
        n = (beats > MAXB) ? MAXB : beats;
        s = '{a.id, addr, 8'(n - 1), a.size, a.burst};
        exp_ar_q.push_back(s);
        beats -= n;
        if (a.burst == B_INCR) addr = addr + (32'(n) << a.size);
      end
    end
  endtask

  function automatic bit busy();
    return (send_q.size() != 0) || (up_q.size() != 0) || (exp_ar_q.size() != 0) ||
           (up_if.arvalid && !ar_clear);
  endfunction

  function automatic logic [1:0] exp_resp(input int beat);
    if (done_bursts != err_burst) return R_OKAY;
`ifdef AXI_RD_SPLIT_ERR_STICKY_EN
    return (beat >= ERR_BEAT) ? R_SLV : R_OKAY;
`else
    return (beat == ERR_BEAT) ? R_SLV : R_OKAY;
`endif
  endfunction

  // One clock: drive at the falling edge, then record the handshakes that
  // the next rising edge will complete.
  task automatic tick();
    ar_t e;
    int beat;
    @(negedge clk);
    cycle++;
    if (ar_clear) begin up_if.arvalid = 1'b0; ar_clear = 1'b0; end
    if (r_clear)  begin dn_if.rvalid = 1'b0; dn_if.rlast = 1'b0; r_clear = 1'b0; end
    if (!up_if.arvalid && send_q.size() > 0 && $urandom_range(99) < p_arv) begin
      cur = send_q.pop_front();
      up_if.arid = cur.id; up_if.araddr = cur.addr; up_if.arlen = cur.len;
      up_if.arsize = cur.size; up_if.arburst = cur.burst; up_if.arvalid = 1'b1;
    end
    up_if.rready  = ($urandom_range(99) < p_rready);
    dn_if.arready = ($urandom_range(99) < p_arready);
    if (!dn_if.rvalid && slave_r_en && sl_q.size() > 0 && $urandom_range(99) < p_rvalid) begin
      sl_data      = $urandom();
      dn_if.rid    = sl_q[0].id;
      dn_if.rdata  = sl_data;
      dn_if.rlast  = (sl_beat == int'(sl_q[0].len));
      dn_if.rresp  = (done_bursts == err_burst && up_beat + 1 == ERR_BEAT) ? R_SLV : R_OKAY;
      dn_if.rvalid = 1'b1;
    end
    #1;
    if (up_if.arvalid && up_if.arready && !ar_clear) begin
      model_accept(cur);
      ar_clear = 1'b1;
    end
    if (dn_if.arvalid && dn_if.arready) begin
      check_eq("dn_ar_expected", 64'(exp_ar_q.size() > 0), 64'd1);
      if (exp_ar_q.size() > 0) begin
        e = exp_ar_q.pop_front();
        check_eq("dn_araddr", dn_if.araddr, e.addr);
        check_eq("dn_arlen", dn_if.arlen, e.len);
        check_eq("dn_arid", dn_if.arid, e.id);
        check_eq("dn_arsize", dn_if.arsize, e.size);
        check_eq("dn_arburst", dn_if.arburst, e.burst);
      end
      sl_q.push_back('{dn_if.arid, dn_if.arlen});
      dn_log.push_back('{dn_if.araddr, dn_if.arlen});
      ar_ticks.push_back(cycle);
      dn_ar_cnt++;
    end
    if (up_if.rvalid && up_if.rready) begin
      check_eq("up_beat_expected", 64'(up_q.size() > 0), 64'd1);
      if (up_q.size() > 0) begin
        beat = up_beat + 1;
        check_eq("up_rdata", up_if.rdata, sl_data);
        check_eq("up_rid", up_if.rid, up_q[0].id);
        check_eq("up_rlast", up_if.rlast, beat == up_q[0].beats);
        check_eq("up_rresp", up_if.rresp, exp_resp(beat));
        if (beat == up_q[0].beats) begin
          void'(up_q.pop_front());
          up_beat = 0;
          done_bursts++;
        end else begin
          up_beat = beat;
        end
      end
    end
    if (dn_if.rvalid && dn_if.rready) begin
      r_clear = 1'b1;
      if (dn_if.rlast) begin
        pop_ticks.push_back(cycle);
        if (sl_q.size() > 0) void'(sl_q.pop_front());
        sl_beat = 0;
      end else begin
        sl_beat++;
      end
    end
  endtask

  task automatic drain(input int budget, input string tag);
    int i = 0;
    while (busy() && i < budget) begin
      tick();
      i++;
    end
    check_eq(tag, 64'(busy()), 64'd0);
  endtask

  task automatic send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                      input logic [2:0] size, input logic [1:0] burst);
    ar_t a;
    a = '{id, addr, len, size, burst};
    send_q.push_back(a);
  endtask

  task automatic check_log(input string tag, input int idx, input logic [31:0] addr,
                           input logic [7:0] len);
    if (dn_log.size() > idx) begin
      check_eq({tag, "_addr"}, dn_log[idx].addr, addr);
      check_eq({tag, "_len"}, dn_log[idx].len, len);
    end
  endtask

  initial begin
    ar_t a;
    int base;
    logic [31:0] r, off, bytes;
    rst = 1'b1;
    up_if.arvalid = 1'b0; up_if.arid = 4'd0; up_if.araddr = 32'd0; up_if.arlen = 8'd0;
    up_if.arsize = 3'd0; up_if.arburst = 2'd0; up_if.rready = 1'b0;
    dn_if.arready = 1'b0; dn_if.rvalid = 1'b0; dn_if.rlast = 1'b0; dn_if.rid = 4'd0;
    dn_if.rdata = 32'd0; dn_if.rresp = 2'd0;
    repeat (3) @(negedge clk);
    check_eq("reset_dn_arvalid", dn_if.arvalid, 1'b0);
    rst = 1'b0;
    tick();
    check_eq("post_reset_arready", up_if.arready, 1'b1);
    check_eq("post_reset_dn_arvalid", dn_if.arvalid, 1'b0);

    // 1: long INCR, size 8 bytes
    dn_log.delete();
    send(4'h3, 32'h1000, 8'd63, 3'd3, B_INCR);
    drain(2000, "t1_timeout");
    check_eq("t1_ar_count", dn_log.size(), 4);
    for (int i = 0; i < 4; i++) check_log("t1", i, 32'h1000 + 32'(i) * 32'h80, 8'd15);

    // 2: INCR with a short tail
    dn_log.delete();
    send(4'h5, 32'h0, 8'd20, 3'd2, B_INCR);
    drain(2000, "t2_timeout");
    check_eq("t2_ar_count", dn_log.size(), 2);
    check_log("t2_0", 0, 32'h0, 8'd15);
    check_log("t2_1", 1, 32'h40, 8'd4);

    // 3: WRAP passes whole, FIXED keeps its address
    dn_log.delete();
    send(4'h1, 32'h18, 8'd7, 3'd3, B_WRAP);
    send(4'h2, 32'h40, 8'd39, 3'd2, B_FIXED);
    drain(2000, "t3_timeout");
    check_eq("t3_ar_count", dn_log.size(), 4);
    check_log("t3_wrap", 0, 32'h18, 8'd7);
    check_log("t3_fix0", 1, 32'h40, 8'd15);
    check_log("t3_fix1", 2, 32'h40, 8'd15);
    check_log("t3_fix2", 3, 32'h40, 8'd7);

    // 4: tracking FIFO full stalls AR issue until a sub-burst completes
    slave_r_en = 1'b0;
    ar_ticks.delete();
    pop_ticks.delete();
    base = dn_ar_cnt;
    send(4'h7, 32'h2000, 8'd63, 3'd2, B_INCR);
    repeat (30) tick();
    check_eq("t4_ar_count", dn_ar_cnt - base, 2);
    check_eq("t4_arvalid_stalled", dn_if.arvalid, 1'b0);
    slave_r_en = 1'b1;
    drain(2000, "t4_timeout");
    check_eq("t4_ar_total", ar_ticks.size(), 4);
    if (ar_ticks.size() >= 3 && pop_ticks.size() >= 1)
      check_eq("t4_third_ar_cycle", ar_ticks[2], pop_ticks[0] + 1);

    // 6: error response on beat 5, then a clean burst
    err_burst = done_bursts;
    send(4'h9, 32'h3000, 8'd31, 3'd2, B_INCR);
    send(4'hA, 32'h4000, 8'd7, 3'd2, B_INCR);
    drain(2000, "t6_timeout");
    err_burst = -1;

    // 5: random bursts under random backpressure
    p_arv = 60; p_rready = 70; p_arready = 70; p_rvalid = 75;
    for (int i = 0; i < 200; i++) begin
      a.id    = 4'($urandom());
      a.len   = 8'($urandom_range(127));
      a.size  = 3'($urandom_range(2));
      a.burst = ($urandom_range(1) == 1) ? B_INCR : B_FIXED;
      r       = $urandom();
      if (a.burst == B_INCR) begin
        bytes  = (32'(a.len) + 32'd1) << a.size;
        off    = $urandom_range(4096 - int'(bytes));
        off    = (off >> a.size) << a.size;
        a.addr = {r[31:12], off[11:0]};
      end else begin
        a.addr = (r >> a.size) << a.size;
      end
      send_q.push_back(a);
    end
    drain(80000, "t5_timeout");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
